// File: rtl/mem_if_pkg.sv
// Shared memory-interface definitions for the data memory responder and its CPU-side initiator.
// Holds the FSM encodings, bus widths, the latched request record and the address check.
package mem_if_pkg;

   localparam int DATA_W = 32;
   localparam int BE_W   = 4;
   localparam int ADDR_W = 32;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [BE_W-1:0]   be;
   } mem_req_t;

   // aw is log2 of the word count; any address bit above the word index is out of range
   function automatic logic addr_err(input logic [ADDR_W-1:0] addr, input int aw);
      return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != '0);
   endfunction

endpackage

// File: rtl/sram_1rw_be.sv
// Single-port DEPTH x 32 storage with per-byte write enables and a registered read port.
// One access per enabled cycle; read data holds until the next enabled read; no backpressure.
module sram_1rw_be
   import mem_if_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              en,
   input  logic [BE_W-1:0]   we,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // Contents are deliberately not reset so data survives a responder reset.
   always_ff @(posedge clk) begin
      if (en) begin
         for (int i = 0; i < BE_W; i++) begin
            if (we[i]) begin
               mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
         if (we == '0) begin
            rdata_q <= mem_q[addr];
         end
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Word-addressed data memory responder: one request at a time, response LATENCY cycles after accept.
// Response is held until rsp_ready; no new request is taken until the cycle after the handshake.
module data_mem_responder
   import mem_if_pkg::*;
#(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [BE_W-1:0]   req_be,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = 3;

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   mem_req_t          req_q, req_d;
   logic              init_q, init_d;

   mem_req_t          acc_req;
   logic              acc_err;
   logic              mem_en;
   logic [BE_W-1:0]   mem_we;
   logic [DATA_W-1:0] mem_rdata;
   logic              rsp_err_int;

   assign req_ready = (state_q == IDLE) && init_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      init_d  = 1'b1;
      acc_req = req_q;
      mem_en  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid && req_ready) begin
               req_d = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};
               // With LATENCY=1 the access happens on the accept edge, so it uses the live inputs.
               acc_req = req_d;
               if (LATENCY == 1) begin
                  state_d = RESP;
                  mem_en  = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_W'(LATENCY - 2);
               end
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d = RESP;
               mem_en  = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign acc_err = addr_err(acc_req.addr, AW);
   assign mem_we  = (mem_en && acc_req.we && !acc_err) ? acc_req.be : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         req_q   <= '0;
         init_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         init_q  <= init_d;
      end
   end

   sram_1rw_be #(
      .DEPTH (DEPTH)
   ) u_sram (
      .clk   (clk),
      .en    (mem_en && !acc_err),
      .we    (mem_we),
      .addr  (acc_req.addr[AW+1:2]),
      .wdata (acc_req.wdata),
      .rdata (mem_rdata)
   );

   // req_q is frozen outside IDLE, so the response fields stay stable while RESP waits.
   assign rsp_valid   = (state_q == RESP);
   assign rsp_err_int = addr_err(req_q.addr, AW);
   assign rsp_err     = rsp_valid && rsp_err_int;
   assign rsp_rdata   = (rsp_valid && !req_q.we && !rsp_err_int) ? mem_rdata : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with three instances: LATENCY 2, 4 and 1.
module tb_data_mem_responder;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n     [3];
   logic        req_valid [3];
   logic        req_ready [3];
   logic        req_we    [3];
   logic [31:0] req_addr  [3];
   logic [31:0] req_wdata [3];
   logic [3:0]  req_be    [3];
   logic        rsp_valid [3];
   logic        rsp_ready [3];
   logic [31:0] rsp_rdata [3];
   logic        rsp_err   [3];

   data_mem_responder #(.DEPTH(256), .LATENCY(2)) u_lat2 (
      .clk(clk), .reset(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

   data_mem_responder #(.DEPTH(256), .LATENCY(4)) u_lat4 (
      .clk(clk), .reset(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

   data_mem_responder #(.DEPTH(256), .LATENCY(1)) u_lat1 (
      .clk(clk), .reset(rst_n[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
      .req_we(req_we[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_be(req_be[2]),
      .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]));

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
   endtask

   // Called #1 after a rising edge. lat = rising edges from the accept edge to the handshake edge.
   task automatic do_txn(input int d, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, output logic [31:0] rdata, output logic err, output int lat);
      int guard;
      rdata = '0;
      err   = 1'b0;
      lat   = -1;
      req_we[d] = we; req_addr[d] = addr; req_wdata[d] = wdata; req_be[d] = be;
      req_valid[d] = 1'b1;
      rsp_ready[d] = 1'b1;
      guard = 0;
      while (!req_ready[d] && guard < 20) begin
         @(posedge clk); #1; guard++;
      end
      if (!req_ready[d]) begin
         check("accept_timeout", 32'd0, 32'd1);
         req_valid[d] = 1'b0;
         return;
      end
      @(posedge clk); #1;
      req_valid[d] = 1'b0;
      lat = 1;
      while (!rsp_valid[d] && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      if (!rsp_valid[d]) begin
         check("rsp_timeout", 32'd0, 32'd1);
         return;
      end
      rdata = rsp_rdata[d];
      err   = rsp_err[d];
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs [15];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;
      int          guard;
      int          seen;
      logic [31:0] cur;

      vecs[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
      vecs[1]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
      vecs[2]  = '{1'b1, 32'h10,  32'h000000AA, 4'h1, 32'h0,        1'b0};
      vecs[3]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEAA, 1'b0};
      vecs[4]  = '{1'b0, 32'h13,  32'h0,        4'h0, 32'h0,        1'b1};
      vecs[5]  = '{1'b1, 32'h0,   32'h11223344, 4'hF, 32'h0,        1'b0};
      vecs[6]  = '{1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
      vecs[7]  = '{1'b0, 32'h0,   32'h0,        4'h0, 32'h11223344, 1'b0};
      vecs[8]  = '{1'b1, 32'h3FC, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
      vecs[9]  = '{1'b0, 32'h3FC, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
      vecs[10] = '{1'b1, 32'h10,  32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
      vecs[11] = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEAA, 1'b0};
      vecs[12] = '{1'b1, 32'h10,  32'h12345600, 4'h6, 32'h0,        1'b0};
      vecs[13] = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDE3456AA, 1'b0};
      vecs[14] = '{1'b0, 32'h402, 32'h0,        4'h0, 32'h0,        1'b1};

      for (int d = 0; d < 3; d++) begin
         rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
         req_wdata[d] = '0; req_be[d] = '0; rsp_ready[d] = 1'b1;
      end

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         check($sformatf("rst%0d_req_ready", d), 32'(req_ready[d]), 32'd0);
         check($sformatf("rst%0d_rsp_valid", d), 32'(rsp_valid[d]), 32'd0);
         check($sformatf("rst%0d_rsp_rdata", d), rsp_rdata[d], 32'd0);
         check($sformatf("rst%0d_rsp_err", d), 32'(rsp_err[d]), 32'd0);
         rst_n[d] = 1'b1;
      end
      #1;
      check("release_req_ready_low", 32'(req_ready[0]), 32'd0);
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++)
         check($sformatf("release%0d_req_ready", d), 32'(req_ready[d]), 32'd1);

      // Vector table on the LATENCY=2 instance
      for (int i = 0; i < 15; i++) begin
         do_txn(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er, lat);
         check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
         check($sformatf("v%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
         check($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
      end

      // Response held under rsp_ready=0 while req_* change underneath
      rsp_ready[0] = 1'b0;
      req_we[0] = 1'b0; req_addr[0] = 32'h10; req_valid[0] = 1'b1;
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      guard = 0;
      while (!rsp_valid[0] && guard < 20) begin
         @(posedge clk); #1; guard++;
      end
      check("hold_first_valid", 32'(rsp_valid[0]), 32'd1);
      req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h14;
      req_wdata[0] = 32'h00000055; req_be[0] = 4'hF;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         check($sformatf("hold%0d_valid", k), 32'(rsp_valid[0]), 32'd1);
         check($sformatf("hold%0d_rdata", k), rsp_rdata[0], 32'hDE3456AA);
         check($sformatf("hold%0d_req_ready", k), 32'(req_ready[0]), 32'd0);
      end
      rsp_ready[0] = 1'b1;
      @(posedge clk); #1;
      check("post_hs_valid", 32'(rsp_valid[0]), 32'd0);
      check("post_hs_rdata", rsp_rdata[0], 32'd0);
      check("post_hs_not_accepted", 32'(req_ready[0]), 32'd1);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      check("next_accepted", 32'(req_ready[0]), 32'd0);
      guard = 0;
      while (!rsp_valid[0] && guard < 20) begin
         @(posedge clk); #1; guard++;
      end
      check("next_rsp_err", 32'(rsp_err[0]), 32'd0);
      @(posedge clk); #1;
      do_txn(0, 1'b0, 32'h14, 32'h0, 4'h0, rd, er, lat);
      check("held_write_landed", rd, 32'h00000055);
      do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
      check("held_read_word_intact", rd, 32'hDE3456AA);

      // LATENCY=4: reset during WAIT aborts the write
      do_txn(1, 1'b1, 32'h20, 32'hA5A5A5A5, 4'hF, rd, er, lat);
      check("l4_latency", 32'(lat), 32'd4);
      req_we[1] = 1'b1; req_addr[1] = 32'h20; req_wdata[1] = 32'h12345678; req_be[1] = 4'hF;
      req_valid[1] = 1'b1;
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      @(posedge clk); #1;
      rst_n[1] = 1'b0;
      #1;
      check("abort_req_ready", 32'(req_ready[1]), 32'd0);
      check("abort_rsp_valid", 32'(rsp_valid[1]), 32'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n[1] = 1'b1;
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         if (rsp_valid[1]) seen++;
      end
      check("abort_no_response", 32'(seen), 32'd0);
      do_txn(1, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
      check("abort_old_value", rd, 32'hA5A5A5A5);
      check("abort_read_err", 32'(er), 32'd0);

      // LATENCY=1: back-to-back reads, one transaction every two cycles
      do_txn(2, 1'b1, 32'h0, 32'h01010101, 4'hF, rd, er, lat);
      check("l1_latency", 32'(lat), 32'd1);
      do_txn(2, 1'b1, 32'h4, 32'h02020202, 4'hF, rd, er, lat);
      cur = 32'h0;
      req_we[2] = 1'b0; req_addr[2] = cur; req_valid[2] = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (c % 2 == 0) begin
            check($sformatf("b2b%0d_valid", c), 32'(rsp_valid[2]), 32'd1);
            check($sformatf("b2b%0d_rdata", c), rsp_rdata[2],
                  (cur == 32'h0) ? 32'h01010101 : 32'h02020202);
            check($sformatf("b2b%0d_req_ready", c), 32'(req_ready[2]), 32'd0);
            cur = (cur == 32'h0) ? 32'h4 : 32'h0;
            req_addr[2] = cur;
         end else begin
            check($sformatf("b2b%0d_valid", c), 32'(rsp_valid[2]), 32'd0);
            check($sformatf("b2b%0d_req_ready", c), 32'(req_ready[2]), 32'd1);
         end
      end
      req_valid[2] = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning number of 32-bit storage words (power of two, 16..1024).
REQ-002 SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to rsp_valid (legal 1..8).
REQ-003 SHALL have ports: clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have ports: reset  input  1  asynchronous, active-low reset; reset=0 resets the block.
REQ-005 SHALL have ports: req_valid  input  1  initiator presents a request.
REQ-006 SHALL have ports: req_ready  output  1  responder accepts a request this cycle.
REQ-007 SHALL have ports: req_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have ports: req_addr  input  32  byte address.
REQ-009 SHALL have ports: req_wdata  input  32  write data.
REQ-010 SHALL have ports: req_be  input  4  byte enables; bit i selects wdata[8i+7:8i].
REQ-011 SHALL have ports: rsp_valid  output  1  response available.
REQ-012 SHALL have ports: rsp_ready  input  1  initiator accepts the response.
REQ-013 SHALL have ports: rsp_rdata  output  32  read data; 0 for writes and errors.
REQ-014 SHALL have ports: rsp_err  output  1  request was misaligned or out of range.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP; req_ready=1 only in IDLE.
REQ-016 SHALL accept a request on the rising edge where req_valid=1 and req_ready=1, latching we/addr/wdata/be.
REQ-017 SHALL, on acceptance, go to RESP if LATENCY=1, else go to WAIT and load the latency counter with LATENCY-2.
REQ-018 SHALL, in WAIT, decrement the counter each cycle and go to RESP on the cycle after it reaches 0; rsp_valid therefore rises exactly LATENCY cycles after the acceptance edge.
REQ-019 SHALL perform the storage access on the edge entering RESP: word index = addr[31:2]; writes update only enabled bytes; reads capture the full word into rsp_rdata.
REQ-020 SHALL flag error when addr[1:0]!=0 or addr[31:2]>=DEPTH: no storage write, rsp_rdata=0, rsp_err=1.
REQ-021 SHALL return rsp_rdata=0 and rsp_err=0 for a successful write; a write with req_be=0 completes normally and changes nothing.
REQ-022 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_valid=1 and rsp_ready=1, then return to IDLE and drive rsp_valid=0 and rsp_rdata/rsp_err to 0.
REQ-023 SHALL NOT accept a new request in the cycle in which a response handshake completes; the next request is accepted at the earliest one cycle later, giving a minimum of LATENCY+1 cycles per transaction.
REQ-024 SHALL ignore req_* inputs outside IDLE; their changes do not affect the transaction in flight.
REQ-025 SHALL give a read after a write to the same word the written data, with no stale-data hazard.

Reset
REQ-026 SHALL, while reset=0, force state IDLE, counter 0, req_ready=0, rsp_valid=0, rsp_rdata=0, and rsp_err=0; req_ready rises on the first clock after reset release.
REQ-027 SHALL abort any in-flight transaction on reset, with no response issued; a write still in WAIT SHALL NOT commit.
REQ-028 SHALL NOT clear storage contents on reset.

Structure
REQ-029 SHALL place state encodings (IDLE=2'd0, WAIT=2'd1, RESP=2'd2), DATA_W=32, and BE_W=4 in shared package mem_if_pkg, to be reused by the CPU-side memory initiator.
REQ-030 SHALL instantiate one sub-module, sram_1rw_be (DEPTH x 32, single port, per-byte write enable, synchronous read), for storage.

Verification
REQ-031 SHALL cover: LATENCY=2; write addr=0x10, wdata=0xDEADBEEF, be=0xF, rsp_ready=1 -> rsp_valid exactly 2 cycles after acceptance, rdata=0, err=0; then read 0x10 -> rdata=0xDEADBEEF.
REQ-032 SHALL cover: after REQ-031, write 0x10, wdata=0x000000AA, be=0x1 -> read 0x10 returns 0xDEADBEAA.
REQ-033 SHALL cover: read addr=0x13 -> err=1, rdata=0; write addr=0x400 (DEPTH=256) -> err=1, and a later read of 0x0 is unchanged.
REQ-034 SHALL cover: rsp_ready=0 held for 5 cycles -> rsp_valid/rdata stable for those cycles, req_ready=0, and a new req_valid is not accepted until the cycle after the handshake.
REQ-035 SHALL cover: LATENCY=4; write 0x20 (0x12345678); assert reset=0 one cycle after acceptance -> no response; after release, read 0x20 returns its pre-write value.
REQ-036 SHALL cover: LATENCY=1; back-to-back reads with rsp_ready=1 -> one transaction every 2 cycles, each rsp_valid one cycle after acceptance.
